font_rom_arbiter: RTL and testbench
===================================

FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of text-overlay requesters sharing one font ROM.
REQ-002 Parameter AW, default 11: font ROM address width, formed as {char[6:0], row[3:0]}.
REQ-003 clk  input  1  system pixel clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester access request, level; held until granted.
REQ-006 req_addr  input  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]; must be stable while req[i] is high.
REQ-007 gnt  output  NREQ  registered one-hot grant; one-cycle pulse per access.
REQ-008 rom_addr  output  AW  registered address to the font_rom addr port.
REQ-009 rom_data  input  8  font_rom data word; valid one cycle after rom_addr is presented.
REQ-010 rd_valid  output  1  rd_data/rd_id valid this cycle.
REQ-011 rd_id  output  log2(NREQ)  index of the requester owning rd_data.
REQ-012 rd_data  output  8  font word; combinational pass-through of rom_data.

Function
REQ-013 The block SHALL issue at most one ROM access per cycle.
REQ-014 Arbitration SHALL be round-robin: the search starts at (last_winner+1) mod NREQ and wraps around; last_winner resets to NREQ-1, so requester 0 has first priority after reset.
REQ-015 On each edge with any req bit high, the block SHALL set gnt to the winner's one-hot bit, rom_addr to that requester's address, and last_winner to the winner's index.
REQ-016 On an edge with no req bit high, gnt SHALL be 0, and rom_addr and last_winner SHALL hold their values.
REQ-017 Pipeline: the stage-1 registers are gnt and rom_addr (edge N); the stage-2 registers are rd_valid and rd_id (edge N+1). rd_valid SHALL equal |gnt from the previous cycle, and rd_id SHALL equal the encoded previous gnt.
REQ-018 The request-to-data latency SHALL be 2 edges: with req sampled at edge N, rd_valid is high in the cycle after edge N+1.
REQ-019 A requester holding req high after its grant SHALL be treated as a new request. With only one requester active it SHALL be granted every cycle (back-to-back). With k active requesters each SHALL be granted once every k cycles.
REQ-020 A requester that drops req in the same cycle it is granted SHALL still receive its data. Dropping req before the grant SHALL cancel the request with no data returned.
REQ-021 When a requester's req rises on the same edge as another's grant, arbitration SHALL use the pointer as updated by that grant.
REQ-022 rd_data SHALL be driven as rom_data in every cycle; consumers qualify it with rd_valid and rd_id.

Reset
REQ-023 While reset_n is low, and immediately on its fall, the block SHALL force gnt=0, rom_addr=0, rd_valid=0, rd_id=0, and last_winner=NREQ-1.
REQ-024 A reset in mid-pipeline SHALL discard all in-flight accesses; no rd_valid SHALL follow for accesses granted before the reset.
REQ-025 The first grant after reset release SHALL occur on the first rising edge with reset_n high and any req high.

Structure
REQ-026 The constants FONT_AW=11, FONT_DW=8 and the default requester count SHALL live in a shared package or include file used by the text modules and font_rom.
REQ-027 A single sub-module, rr_pick (a combinational round-robin priority picker: req vector plus pointer in, one-hot plus index out), SHALL hold the arbitration logic.
REQ-028 font_rom SHALL be instantiated outside this block; the arbiter only drives its address and receives its data.

Verification
REQ-029 Reset: assert reset_n=0 mid-stream -> gnt, rd_valid, rom_addr go to 0 asynchronously; after release, no rd_valid appears for the flushed accesses.
REQ-030 Single requester: req=4'b0010 held for 5 cycles with addr 11'h611 ('a' row 1) -> gnt=0010 on 5 consecutive edges; rd_valid high with rd_id=1 for 5 cycles starting 2 edges after the first request; rd_data matches the ROM word for 11'h611.
REQ-031 All four requesters held -> grant order 0,1,2,3,0,1,...; each requester is granted exactly once per 4 cycles.
REQ-032 Requester 2 drops req in its grant cycle while 0 and 3 stay active -> requester 2's data is still returned with rd_id=2; the next grant goes to 3, then 0.
REQ-033 Cancel: requester 1 raises and lowers req before it is granted while 0 is busy -> no rd_valid with rd_id=1.
REQ-034 Idle gap: requests stop for 3 cycles -> gnt=0 and rd_valid=0 after the pipeline drains; rom_addr holds its last value; the next single request is granted on the next edge.

Source files
------------

// File: rtl/font_rom_arbiter_pkg.sv
// Shared constants for the text-overlay path: font ROM geometry and the default
// number of overlay requesters sharing the ROM. Used by the text modules,
// font_rom and font_rom_arbiter.
package font_rom_arbiter_pkg;

    // Font ROM address is {char[6:0], row[3:0]}.
    localparam int FONT_AW   = 11;
    // One 8-pixel row of a glyph per ROM word.
    localparam int FONT_DW   = 8;
    // Default number of overlay requesters.
    localparam int FONT_NREQ = 4;

    // Width of a requester index; kept at least 1 so a single-requester
    // build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/font_rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// The search starts one past the previous winner and wraps, so the requester
// just served has the lowest priority next time.
//
// Ports:
//   req_i  NREQ  request vector
//   ptr_i  IW    index of the previous winner
//   gnt_o  NREQ  one-hot winner (all zero when nothing requests)
//   idx_o  IW    index of the winner (0 when nothing requests)
//   any_o  1     at least one request present
module rr_pick
    import font_rom_arbiter_pkg::*;
#(
    parameter int NREQ = FONT_NREQ,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves a variable unassigned, which would infer a latch.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // Offsets 1..NREQ visit every requester once, ending on the previous
        // winner itself, which is therefore only picked when it is alone.
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(ptr_i) + off) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM between NREQ text-overlay
// requesters, one access per cycle, round-robin.
//
// Pipeline:
//   edge N   : winner picked, gnt pulses, rom_addr loaded
//   edge N+1 : ROM returns its word, rd_valid/rd_id mark the owner
//
// Ports:
//   clk       pixel clock
//   reset_n   asynchronous active-low reset
//   req       per-requester level request, held until granted
//   req_addr  packed addresses, requester i at [i*AW +: AW]
//   gnt       registered one-hot grant pulse
//   rom_addr  registered address to font_rom
//   rom_data  font_rom read word (one cycle after rom_addr)
//   rd_valid  rd_data/rd_id valid this cycle
//   rd_id     owner of rd_data
//   rd_data   rom_data passed straight through
module font_rom_arbiter
    import font_rom_arbiter_pkg::*;
#(
    parameter int  NREQ = FONT_NREQ,
    parameter int  AW   = FONT_AW,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rom_addr,
    input  logic [FONT_DW-1:0]   rom_data,
    output logic                 rd_valid,
    output logic [IW-1:0]        rd_id,
    output logic [FONT_DW-1:0]   rd_data
);

    // Stage 1: grant and address; last_q is the round-robin pointer.
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [IW-1:0]   last_q, last_d;
    // Stage 2: ownership of the word coming back from the ROM.
    logic            rd_valid_q, rd_valid_d;
    logic [IW-1:0]   rd_id_q, rd_id_d;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [AW-1:0]   sel_addr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (last_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // One-hot address mux: OR of the winner's slice.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        gnt_d      = '0;
        rom_addr_d = rom_addr_q;
        last_d     = last_q;
        if (pick_any) begin
            gnt_d      = pick_oh;
            rom_addr_d = sel_addr;
            last_d     = pick_idx;
        end
        // last_q was loaded on the same edge as gnt_q, so while gnt_q is
        // non-zero it already holds the encoded grant.
        rd_valid_d = |gnt_q;
        rd_id_d    = rd_valid_d ? last_q : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            gnt_q      <= '0;
            rom_addr_q <= '0;
            last_q     <= IW'(NREQ - 1);
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rom_addr_q <= rom_addr_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign gnt      = gnt_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = rom_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed scenarios with literal expectations,
// then randomized requests and reset pulses, all compared every cycle against
// a behavioural round-robin model. The font ROM is a synchronous table here.
module tb_font_rom_arbiter;
    import font_rom_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = FONT_AW;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ-1:0]      gnt;
    logic [AW-1:0]        rom_addr;
    logic [FONT_DW-1:0]   rom_data;
    logic                 rd_valid;
    logic [1:0]           rd_id;
    logic [FONT_DW-1:0]   rd_data;

    font_rom_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font ROM contents: any fixed scramble of the address.
    function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Inputs as seen at each rising edge, and whether reset was released then.
    logic [NREQ-1:0]    s_req;
    logic [NREQ*AW-1:0] s_addr;
    logic               s_live;

    always @(posedge clk) begin
        s_req  <= req;
        s_addr <= req_addr;
        s_live <= reset_n;
    end

    int              m_lw;       // last winner index
    logic [NREQ-1:0] m_gnt;      // grant pulse expected this cycle
    logic [AW-1:0]   m_addr;     // address on the ROM port
    logic            m_valid;    // a read result is due this cycle
    int              m_id;       // its owner
    logic [AW-1:0]   m_rd_addr;  // the address it was read from

    task automatic model_reset();
        m_lw    = NREQ - 1;
        m_gnt   = '0;
        m_addr  = '0;
        m_valid = 1'b0;
        m_id    = 0;
    endtask

    // One rising edge: the data owed for last cycle's grant comes back, and
    // a new winner is searched from one past the previous winner.
    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
        bit found;
        int w;
        m_valid   = (m_gnt != '0);
        m_id      = m_lw;
        m_rd_addr = m_addr;
        m_gnt     = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w = (m_lw + k) % NREQ;
            if (!found && r[w]) begin
                found    = 1'b1;
                m_gnt[w] = 1'b1;
                m_addr   = a[w*AW +: AW];
                m_lw     = w;
            end
        end
    endtask

    always @(negedge clk) begin
        if (s_live !== 1'b1) model_reset();
        else                 model_step(s_req, s_addr);
        check("model_gnt", 32'(gnt), 32'(m_gnt));
        check("model_rom_addr", 32'(rom_addr), 32'(m_addr));
        check("model_rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_valid) begin
            check("model_rd_id", 32'(rd_id), 32'(m_id));
            check("model_rd_data", 32'(rd_data), 32'(rom_fn(m_rd_addr)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Pulse reset across one rising edge; returns at a falling edge with
    // reset released and no requests.
    task automatic do_reset();
        req = '0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        check("reset_rom_addr", 32'(rom_addr), 32'h0);
        reset_n = 1'b1;

        // Single requester held for 5 cycles: back-to-back grants.
        set_addr(1, 11'h611);
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("single_gnt", 32'(gnt), 32'h2);
            check("single_rom_addr", 32'(rom_addr), 32'h611);
            if (c >= 1) begin
                check("single_rd_valid", 32'(rd_valid), 32'h1);
                check("single_rd_id", 32'(rd_id), 32'h1);
                check("single_rd_data", 32'(rd_data), 32'(rom_fn(11'h611)));
            end
        end
        req = '0;
        @(negedge clk);
        check("single_tail_gnt", 32'(gnt), 32'h0);
        check("single_tail_valid", 32'(rd_valid), 32'h1);
        @(negedge clk);
        check("single_drained", 32'(rd_valid), 32'h0);

        // All four held: strict rotation 0,1,2,3,...
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(11'h100 * (i + 1) + 11'h11 * i));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
        end

        // Mid-stream reset: outputs clear immediately, flushed accesses vanish.
        #2 reset_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_rom_addr", 32'(rom_addr), 32'h0);
        check("async_rd_valid", 32'(rd_valid), 32'h0);
        check("async_rd_id", 32'(rd_id), 32'h0);
        @(negedge clk);
        req     = '0;
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("flush_rd_valid", 32'(rd_valid), 32'h0);
            check("flush_gnt", 32'(gnt), 32'h0);
        end
        req = 4'b1111;
        @(negedge clk);
        check("post_reset_first", 32'(gnt), 32'h1);
        req = '0;

        // Requester 2 drops in its grant cycle while 0 and 3 stay busy.
        do_reset();
        set_addr(0, 11'h0A0);
        set_addr(2, 11'h2B2);
        set_addr(3, 11'h3C3);
        req = 4'b1101;
        @(negedge clk);
        check("drop_gnt0", 32'(gnt), 32'h1);
        @(negedge clk);
        check("drop_gnt2", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        @(negedge clk);
        check("drop_gnt3", 32'(gnt), 32'h8);
        check("drop_valid", 32'(rd_valid), 32'h1);
        check("drop_id", 32'(rd_id), 32'h2);
        check("drop_data", 32'(rd_data), 32'(rom_fn(11'h2B2)));
        @(negedge clk);
        check("drop_gnt0_again", 32'(gnt), 32'h1);
        req = '0;

        // Cancel: requester 1 pulses req between edges while 0 is busy.
        do_reset();
        set_addr(0, 11'h0F0);
        req = 4'b0001;
        @(negedge clk);
        #1 set_addr(1, 11'h1E1);
        req[1] = 1'b1;
        #2 req[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("cancel_gnt", 32'(gnt), 32'h1);
            check("cancel_valid", 32'(rd_valid), 32'h1);
            check("cancel_id", 32'(rd_id), 32'h0);
        end
        req = '0;

        // Idle gap: pipeline drains, rom_addr holds, next request wins at once.
        do_reset();
        set_addr(3, 11'h5C3);
        req = 4'b1000;
        repeat (2) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_last_valid", 32'(rd_valid), 32'h1);
        check("idle_hold_addr", 32'(rom_addr), 32'h5C3);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_valid", 32'(rd_valid), 32'h0);
            check("idle_hold_addr", 32'(rom_addr), 32'h5C3);
        end
        set_addr(1, 11'h2A7);
        req = 4'b0010;
        @(negedge clk);
        check("idle_resume_gnt", 32'(gnt), 32'h2);
        check("idle_resume_addr", 32'(rom_addr), 32'h2A7);
        req = '0;

        // Randomized traffic with occasional mid-cycle resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) set_addr(i, AW'($urandom_range(0, (1 << AW) - 1)));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
